// File: rtl/inta_ack_sequencer_if.sv
// Bundle between the interrupt-acknowledge sequencer and its CPU/config environment.
`default_nettype none

interface inta_ack_sequencer_if;
    logic [7:0] irr;
    logic [7:0] imr;
    logic       inta;
    logic [4:0] icw2;
    logic       sngl;
    logic       sp_en;
    logic [7:0] icw3;
    logic       cas_sel;
    logic       aeoi;
    logic       eoi_cmd;
    logic       eoi_spec;
    logic [2:0] eoi_level;
    logic       int_req;
    logic [2:0] ir_level;
    logic [7:0] clr_irr;
    logic [7:0] isr;
    logic [7:0] vector;
    logic       vector_oe;

    modport master (
        output irr, imr, inta, icw2, sngl, sp_en, icw3, cas_sel,
               aeoi, eoi_cmd, eoi_spec, eoi_level,
        input  int_req, ir_level, clr_irr, isr, vector, vector_oe
    );

    modport slave (
        input  irr, imr, inta, icw2, sngl, sp_en, icw3, cas_sel,
               aeoi, eoi_cmd, eoi_spec, eoi_level,
        output int_req, ir_level, clr_irr, isr, vector, vector_oe
    );
endinterface

`default_nettype wire

// File: rtl/inta_ack_sequencer.sv
// 8259-style interrupt-acknowledge sequencer: priority resolve, 8086 two-pulse INTA
// tracking, in-service register ownership and vector byte generation.
`default_nettype none

module inta_ack_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int GAP_TIMEOUT = 64
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    inta_ack_sequencer_if.slave   bus
);

    localparam int GW = $clog2(GAP_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PEND = 3'd1,
        S_ACK1 = 3'd2,
        S_GAP  = 3'd3,
        S_ACK2 = 3'd4
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   int_q;
    logic [2:0]             ir_level_q;
    logic [7:0]             clr_irr_q;
    logic [7:0]             isr_q;
    logic [7:0]             vector_q;
    logic                   vector_oe_q;
    logic                   spurious_q;
    logic [GW-1:0]          gap_q;

    logic       inta_s;
    logic       le;
    logic       te;
    logic [7:0] cand;
    logic [7:0] win_oh;
    logic [7:0] isr_low;
    logic [2:0] win_idx;
    logic       valid;
    logic [7:0] eoi_clr;
    logic [7:0] isr_kept;
    logic       oe_en;

    assign inta_s = sync_q[SYNC_STAGES-1];
    assign le     = prev_q & ~inta_s;
    assign te     = ~prev_q & inta_s;

    // x & -x isolates the lowest set bit; one-hot compare then orders priorities.
    assign cand    = bus.irr & ~bus.imr;
    assign win_oh  = cand & (~cand + 8'd1);
    assign isr_low = isr_q & (~isr_q + 8'd1);
    assign valid   = (cand != 8'd0) && ((isr_q == 8'd0) || (win_oh < isr_low));

    always_comb begin
        win_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (cand[i]) win_idx = 3'(i);
        end
    end

    always_comb begin
        eoi_clr = 8'd0;
        if (bus.eoi_cmd && !bus.aeoi) begin
            eoi_clr = bus.eoi_spec ? (8'd1 << bus.eoi_level) : isr_low;
        end
    end

    // EOI works on the pre-update ISR; sets/AEOI clears are layered on top.
    assign isr_kept = isr_q & ~eoi_clr;
    assign oe_en    = bus.sngl | (bus.sp_en & ~bus.icw3[ir_level_q])
                    | (~bus.sp_en & bus.cas_sel);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sync_q      <= '1;
            prev_q      <= 1'b1;
            int_q       <= 1'b0;
            ir_level_q  <= 3'd0;
            clr_irr_q   <= 8'd0;
            isr_q       <= 8'd0;
            vector_q    <= 8'd0;
            vector_oe_q <= 1'b0;
            spurious_q  <= 1'b0;
            gap_q       <= '0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.inta};
            prev_q    <= inta_s;
            clr_irr_q <= 8'd0;
            isr_q     <= isr_kept;

            case (state_q)
                S_IDLE: begin
                    if (le) begin
                        state_q    <= S_ACK1;
                        ir_level_q <= 3'd7;
                        vector_q   <= {bus.icw2, 3'd7};
                        spurious_q <= 1'b1;
                    end else if (valid) begin
                        state_q <= S_PEND;
                        int_q   <= 1'b1;
                    end
                end
                S_PEND: begin
                    if (le) begin
                        state_q <= S_ACK1;
                        int_q   <= 1'b0;
                        if (valid) begin
                            ir_level_q <= win_idx;
                            vector_q   <= {bus.icw2, win_idx};
                            isr_q      <= isr_kept | win_oh;
                            clr_irr_q  <= win_oh;
                            spurious_q <= 1'b0;
                        end else begin
                            ir_level_q <= 3'd7;
                            vector_q   <= {bus.icw2, 3'd7};
                            spurious_q <= 1'b1;
                        end
                    end
                end
                S_ACK1: begin
                    int_q <= 1'b0;
                    if (te) begin
                        state_q <= S_GAP;
                        gap_q   <= '0;
                    end
                end
                S_GAP: begin
                    if (le) begin
                        state_q     <= S_ACK2;
                        vector_oe_q <= oe_en;
                    end else if (gap_q == GW'(GAP_TIMEOUT - 1)) begin
                        state_q     <= S_IDLE;
                        vector_oe_q <= 1'b0;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                S_ACK2: begin
                    if (te) begin
                        state_q     <= S_IDLE;
                        vector_oe_q <= 1'b0;
                        if (bus.aeoi && !spurious_q) begin
                            isr_q <= isr_kept & ~(8'd1 << ir_level_q);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.int_req   = int_q;
    assign bus.ir_level  = ir_level_q;
    assign bus.clr_irr   = clr_irr_q;
    assign bus.isr       = isr_q;
    assign bus.vector    = vector_q;
    assign bus.vector_oe = vector_oe_q;

endmodule

`default_nettype wire

// File: tb/tb_inta_ack_sequencer.sv
// Directed self-checking bench for inta_ack_sequencer.
`default_nettype none

module tb_inta_ack_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    inta_ack_sequencer_if bus ();

    inta_ack_sequencer #(
        .SYNC_STAGES (2),
        .GAP_TIMEOUT (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    int         clr_cnt  = 0;
    int         oe_cnt   = 0;
    logic [7:0] clr_last = 8'd0;
    int         c0;
    int         o0;

    always @(negedge clk) begin
        if (bus.clr_irr != 8'd0) begin
            clr_cnt  <= clr_cnt + 1;
            clr_last <= bus.clr_irr;
        end
        if (bus.vector_oe) oe_cnt <= oe_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic inta_fall();
        bus.inta = 1'b0;
        tick(5);
    endtask

    task automatic inta_rise();
        bus.inta = 1'b1;
        tick(5);
    endtask

    task automatic eoi(input logic spec, input logic [2:0] lvl);
        bus.eoi_cmd   = 1'b1;
        bus.eoi_spec  = spec;
        bus.eoi_level = lvl;
        tick(1);
        bus.eoi_cmd = 1'b0;
        tick(1);
    endtask

    // Raise a request, let it reach INT, take the first INTA and drop the request.
    task automatic first_ack(input logic [7:0] req);
        bus.irr = req;
        tick(2);
        inta_fall();
        bus.irr = 8'd0;
    endtask

    initial begin
        bus.irr = 8'd0;  bus.imr = 8'd0;   bus.inta = 1'b1;    bus.icw2 = 5'h08;
        bus.sngl = 1'b1; bus.sp_en = 1'b1; bus.icw3 = 8'd0;    bus.cas_sel = 1'b0;
        bus.aeoi = 1'b0; bus.eoi_cmd = 1'b0; bus.eoi_spec = 1'b0; bus.eoi_level = 3'd0;
        tick(3);
        check_eq("rst_int", bus.int_req, 0);
        check_eq("rst_isr", bus.isr, 0);
        check_eq("rst_vec", bus.vector, 0);
        check_eq("rst_oe", bus.vector_oe, 0);
        rst_n = 1'b1;
        tick(2);

        // T1: single PIC, IR3
        bus.irr = 8'h08;
        tick(2);
        check_eq("t1_int", bus.int_req, 1);
        c0 = clr_cnt;
        inta_fall();
        bus.irr = 8'd0;
        check_eq("t1_isr", bus.isr, 8'h08);
        check_eq("t1_lvl", bus.ir_level, 3);
        check_eq("t1_int_drop", bus.int_req, 0);
        check_eq("t1_oe_ack1", bus.vector_oe, 0);
        check_eq("t1_clr_cnt", clr_cnt - c0, 1);
        check_eq("t1_clr_bit", clr_last, 8'h08);
        inta_rise();
        check_eq("t1_oe_gap", bus.vector_oe, 0);
        inta_fall();
        check_eq("t1_vec", bus.vector, 8'h43);
        check_eq("t1_oe_ack2", bus.vector_oe, 1);
        inta_rise();
        check_eq("t1_oe_end", bus.vector_oe, 0);
        check_eq("t1_isr_kept", bus.isr, 8'h08);

        // T2: nesting under ISR=04
        eoi(1'b0, 3'd0);
        check_eq("t2_eoi", bus.isr, 8'h00);
        first_ack(8'h04);
        inta_rise(); inta_fall(); inta_rise();
        check_eq("t2_isr4", bus.isr, 8'h04);
        bus.irr = 8'h10;
        tick(4);
        check_eq("t2_blocked", bus.int_req, 0);
        bus.irr = 8'h02;
        tick(2);
        check_eq("t2_int", bus.int_req, 1);
        inta_fall();
        bus.irr = 8'd0;
        check_eq("t2_isr6", bus.isr, 8'h06);
        check_eq("t2_lvl", bus.ir_level, 1);
        inta_rise(); inta_fall(); inta_rise();
        check_eq("t2_vec", bus.vector, 8'h41);

        // T3: specific EOIs then a spurious ack
        eoi(1'b1, 3'd1);
        check_eq("t3_eoi1", bus.isr, 8'h04);
        eoi(1'b1, 3'd2);
        check_eq("t3_eoi2", bus.isr, 8'h00);
        bus.irr = 8'h08;
        tick(2);
        bus.irr = 8'd0;
        tick(3);
        check_eq("t3_int_held", bus.int_req, 1);
        c0 = clr_cnt;
        inta_fall();
        check_eq("t3_lvl", bus.ir_level, 7);
        inta_rise(); inta_fall(); inta_rise();
        check_eq("t3_vec", bus.vector, 8'h47);
        check_eq("t3_isr", bus.isr, 8'h00);
        check_eq("t3_clr", clr_cnt - c0, 0);

        // T4: master with slave on IR2, then slave addressed
        bus.sngl = 1'b0; bus.sp_en = 1'b1; bus.icw3 = 8'h04;
        o0 = oe_cnt;
        first_ack(8'h04);
        inta_rise(); inta_fall(); inta_rise();
        check_eq("t4_master_oe", oe_cnt - o0, 0);
        check_eq("t4_isr", bus.isr, 8'h04);
        eoi(1'b0, 3'd0);
        bus.sp_en = 1'b0; bus.cas_sel = 1'b1;
        first_ack(8'h04);
        inta_rise(); inta_fall();
        check_eq("t4_slave_oe", bus.vector_oe, 1);
        inta_rise();
        eoi(1'b0, 3'd0);
        bus.sngl = 1'b1; bus.sp_en = 1'b1; bus.cas_sel = 1'b0; bus.icw3 = 8'd0;

        // T5: AEOI then manual EOIs
        bus.aeoi = 1'b1;
        first_ack(8'h20);
        check_eq("t5_aeoi_set", bus.isr, 8'h20);
        inta_rise(); inta_fall();
        check_eq("t5_aeoi_ack2", bus.isr, 8'h20);
        inta_rise();
        check_eq("t5_aeoi_clr", bus.isr, 8'h00);
        bus.aeoi = 1'b0;
        first_ack(8'h20);
        inta_rise(); inta_fall(); inta_rise();
        first_ack(8'h04);
        inta_rise(); inta_fall(); inta_rise();
        check_eq("t5_isr24", bus.isr, 8'h24);
        eoi(1'b0, 3'd0);
        check_eq("t5_nonspec", bus.isr, 8'h20);
        eoi(1'b1, 3'd5);
        check_eq("t5_spec", bus.isr, 8'h00);

        // T6: gap timeout, then reset in ACK2
        o0 = oe_cnt;
        first_ack(8'h01);
        inta_rise();
        tick(16 + 10);
        check_eq("t6_oe_never", oe_cnt - o0, 0);
        check_eq("t6_isr_kept", bus.isr, 8'h01);
        check_eq("t6_int_idle", bus.int_req, 0);
        eoi(1'b0, 3'd0);
        first_ack(8'h02);
        inta_rise(); inta_fall();
        check_eq("t6_oe_pre", bus.vector_oe, 1);
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_oe", bus.vector_oe, 0);
        check_eq("t6_rst_isr", bus.isr, 0);
        check_eq("t6_rst_vec", bus.vector, 0);
        check_eq("t6_rst_lvl", bus.ir_level, 0);
        check_eq("t6_rst_int", bus.int_req, 0);
        bus.inta = 1'b1;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
